// File: rtl/arm_cpu_core.sv
// Single-cycle LEGv8 subset core: fetch, decode, execute and retire in one clock.
// Architectural state is only the PC and a 32 x 64-bit register file (X31 = XZR).
module arm_cpu_core (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] instruction,
  input  logic [63:0] mem_read_data,
  output logic [63:0] PC,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic        control_memwrite,
  output logic        control_memread
);

  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [9:0]  OpAddi = 10'b1001000100;
  localparam logic [9:0]  OpSubi = 10'b1101000100;
  localparam logic [7:0]  OpCbz  = 8'b10110100;
  localparam logic [5:0]  OpB    = 6'b000101;

  logic [63:0] pc_q, pc_d;
  logic [63:0] regs_q [32];

  logic [4:0]  rd, rn, rm, rd2_addr;
  logic        is_add, is_sub, is_and, is_orr, is_addi, is_subi;
  logic        is_ldur, is_stur, is_cbz, is_b;
  logic [63:0] rd1, rd2, alu, wb_data;
  logic [63:0] imm12_ext, addr9_ext, cond19_ext, addr26_ext;
  logic        wb_en;

  assign rd = instruction[4:0];
  assign rn = instruction[9:5];
  assign rm = instruction[20:16];

  assign is_add  = (instruction[31:21] == OpAdd);
  assign is_sub  = (instruction[31:21] == OpSub);
  assign is_and  = (instruction[31:21] == OpAnd);
  assign is_orr  = (instruction[31:21] == OpOrr);
  assign is_ldur = (instruction[31:21] == OpLdur);
  assign is_stur = (instruction[31:21] == OpStur);
  assign is_addi = (instruction[31:22] == OpAddi);
  assign is_subi = (instruction[31:22] == OpSubi);
  assign is_cbz  = (instruction[31:24] == OpCbz);
  assign is_b    = (instruction[31:26] == OpB);

  assign imm12_ext  = {52'b0, instruction[21:10]};
  assign addr9_ext  = {{55{instruction[20]}}, instruction[20:12]};
  assign cond19_ext = {{43{instruction[23]}}, instruction[23:5], 2'b00};
  assign addr26_ext = {{36{instruction[25]}}, instruction[25:0], 2'b00};

  // Stores and CBZ read Rt on the second port; R-format reads Rm.
  assign rd2_addr = (is_stur || is_cbz) ? rd : rm;
  assign rd1      = (rn == 5'd31) ? 64'd0 : regs_q[rn];
  assign rd2      = (rd2_addr == 5'd31) ? 64'd0 : regs_q[rd2_addr];

  always_comb begin
    alu = rd1 + rd2;
    if (is_sub) begin
      alu = rd1 - rd2;
    end else if (is_and) begin
      alu = rd1 & rd2;
    end else if (is_orr) begin
      alu = rd1 | rd2;
    end else if (is_addi) begin
      alu = rd1 + imm12_ext;
    end else if (is_subi) begin
      alu = rd1 - imm12_ext;
    end else if (is_ldur || is_stur) begin
      alu = rd1 + addr9_ext;
    end
  end

  assign wb_en   = (is_add || is_sub || is_and || is_orr || is_addi || is_subi || is_ldur) &&
                   (rd != 5'd31);
  assign wb_data = is_ldur ? mem_read_data : alu;

  always_comb begin
    pc_d = pc_q + 64'd4;
    if (is_b) begin
      pc_d = pc_q + addr26_ext;
    end else if (is_cbz && (rd2 == 64'd0)) begin
      pc_d = pc_q + cond19_ext;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      pc_q <= 64'd0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 64'd0;
      end
    end else begin
      pc_q <= pc_d;
      if (wb_en) begin
        regs_q[rd] <= wb_data;
      end
    end
  end

  assign PC               = pc_q;
  assign mem_address      = alu;
  assign mem_write_data   = rd2;
  assign control_memwrite = is_stur;
  assign control_memread  = is_ldur;

endmodule

// File: tb/tb_arm_cpu_core.sv
// Self-checking bench for arm_cpu_core; registers are observed through a STUR peek
// (mem_write_data shows Rt combinationally) while no clock edge occurs.
module tb_arm_cpu_core;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] instruction;
  logic [63:0] mem_read_data;
  logic [63:0] PC, mem_address, mem_write_data;
  logic        control_memwrite, control_memread;

  logic [31:0] imem [256];
  logic        peek_en = 1'b0;
  logic [31:0] peek_instr = 32'd0;
  logic [63:0] dmem = 64'd0;
  logic [63:0] exp_q [$];
  logic [63:0] exp_v, got;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign instruction   = peek_en ? peek_instr : imem[PC[9:2]];
  assign mem_read_data = dmem;

  always #50 CLOCK = ~CLOCK;

  arm_cpu_core dut (
    .CLOCK            (CLOCK),
    .RESET            (RESET),
    .instruction      (instruction),
    .mem_read_data    (mem_read_data),
    .PC               (PC),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .control_memwrite (control_memwrite),
    .control_memread  (control_memread)
  );

  function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {op, imm, rn, rd};
  endfunction

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] a9,
                                        input logic [4:0] rn, input logic [4:0] rt);
    return {op, a9, 2'b00, rn, rt};
  endfunction

  localparam logic [9:0]  ADDI = 10'b1001000100;
  localparam logic [9:0]  SUBI = 10'b1101000100;
  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] AND  = 11'b10001010000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b1;
    #1;
  endtask

  // Combinational register read via STUR Xr,[XZR,#0]; never spans a clock edge.
  task automatic peek(input logic [4:0] r, output logic [63:0] v);
    peek_instr = enc_d(STUR, 9'd0, 5'd31, r);
    peek_en    = 1'b1;
    #1;
    v          = mem_write_data;
    peek_en    = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_imem();
    RESET = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    n_cmp++;
    if (PC !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_pc: got %h want 0", PC);
    end
    for (int r = 0; r < 32; r++) exp_q.push_back(64'd0);
    for (int r = 0; r < 32; r++) begin
      peek(r[4:0], got);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL reset_reg X%0d: got %h want %h", r, got, exp_v);
      end
    end
    @(negedge CLOCK);
    RESET = 1'b1;
    #1;
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd4);
    exp_q.push_back(64'd8);
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (PC !== exp_v) begin
        n_bad++;
        $display("FAIL reset_pc_seq: got %h want %h", PC, exp_v);
      end
      if (exp_q.size() > 0) step();
    end
  endtask

  task automatic test_arith();
    logic [4:0] regs [7];
    clear_imem();
    imem[0] = enc_i(ADDI, 12'd5, 5'd31, 5'd1);
    imem[1] = enc_i(ADDI, 12'd3, 5'd31, 5'd2);
    imem[2] = enc_r(SUB, 5'd2, 5'd1, 5'd3);
    imem[3] = enc_r(ORR, 5'd2, 5'd1, 5'd4);
    imem[4] = enc_r(AND, 5'd2, 5'd1, 5'd5);
    imem[5] = enc_i(SUBI, 12'd1, 5'd31, 5'd6);
    imem[6] = enc_r(ADD, 5'd2, 5'd1, 5'd7);
    do_reset();
    repeat (7) step();
    regs = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
    exp_q.push_back(64'd5);
    exp_q.push_back(64'd3);
    exp_q.push_back(64'd2);
    exp_q.push_back(64'd7);
    exp_q.push_back(64'd1);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    exp_q.push_back(64'd8);
    for (int i = 0; i < 7; i++) begin
      peek(regs[i], got);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL arith X%0d: got %h want %h", regs[i], got, exp_v);
      end
    end
  endtask

  task automatic test_memory();
    clear_imem();
    imem[0] = enc_i(ADDI, 12'd16, 5'd31, 5'd1);
    imem[1] = enc_i(ADDI, 12'hAB, 5'd31, 5'd2);
    imem[2] = enc_d(STUR, 9'd8, 5'd1, 5'd2);
    imem[3] = enc_d(LDUR, 9'd8, 5'd1, 5'd3);
    imem[4] = enc_d(LDUR, 9'h1F8, 5'd1, 5'd4);
    dmem = 64'd0;
    do_reset();
    repeat (2) step();
    // STUR cycle: {memwrite, memread, address, write data}
    exp_q.push_back({63'd0, 1'b1});
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd24);
    exp_q.push_back(64'hAB);
    got = {63'd0, control_memwrite};
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL stur_memwrite: got %h want %h", got, exp_v); end
    got = {63'd0, control_memread};
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL stur_memread: got %h want %h", got, exp_v); end
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (mem_address !== exp_v) begin
      n_bad++; $display("FAIL stur_addr: got %h want %h", mem_address, exp_v);
    end
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (mem_write_data !== exp_v) begin
      n_bad++; $display("FAIL stur_wdata: got %h want %h", mem_write_data, exp_v);
    end
    step();
    dmem = 64'hAB;
    #1;
    n_cmp++;
    if ({control_memread, control_memwrite, mem_address} !== {1'b1, 1'b0, 64'd24}) begin
      n_bad++;
      $display("FAIL ldur_ctrl: got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=18",
               control_memread, control_memwrite, mem_address);
    end
    step();
    dmem = 64'h1234_5678;
    #1;
    n_cmp++;
    if ({control_memread, control_memwrite, mem_address} !== {1'b1, 1'b0, 64'd8}) begin
      n_bad++;
      $display("FAIL ldur_negoff: got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=8",
               control_memread, control_memwrite, mem_address);
    end
    step();
    n_cmp++;
    if ({control_memread, control_memwrite} !== 2'b00) begin
      n_bad++;
      $display("FAIL nop_ctrl: got rd=%b wr=%b want 0 0", control_memread, control_memwrite);
    end
    exp_q.push_back(64'hAB);
    exp_q.push_back(64'h1234_5678);
    for (int r = 3; r <= 4; r++) begin
      peek(r[4:0], got);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL load_X%0d: got %h want %h", r, got, exp_v);
      end
    end
  endtask

  task automatic test_branch();
    clear_imem();
    imem[0]  = enc_i(ADDI, 12'd5, 5'd31, 5'd1);
    imem[8]  = {8'b10110100, 19'd3, 5'd31};
    imem[11] = {8'b10110100, 19'd3, 5'd1};
    imem[12] = {6'b000101, 26'd4};
    imem[16] = {6'b000101, 26'h3FF_FFFE};
    do_reset();
    for (int a = 0; a <= 32'h20; a += 4) exp_q.push_back(64'(a));
    exp_q.push_back(64'h2C);
    exp_q.push_back(64'h30);
    exp_q.push_back(64'h40);
    exp_q.push_back(64'h38);
    exp_q.push_back(64'h3C);
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (PC !== exp_v) begin
        n_bad++;
        $display("FAIL branch_pc: got %h want %h", PC, exp_v);
      end
      if (exp_q.size() > 0) step();
    end
  endtask

  task automatic test_xzr_nop();
    clear_imem();
    imem[0] = enc_i(ADDI, 12'd7, 5'd31, 5'd1);
    imem[1] = enc_i(ADDI, 12'd9, 5'd31, 5'd31);
    imem[2] = 32'h0000_0000;
    do_reset();
    repeat (3) step();
    n_cmp++;
    if (PC !== 64'd12) begin n_bad++; $display("FAIL nop_pc: got %h want c", PC); end
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd7);
    peek(5'd31, got);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL xzr: got %h want %h", got, exp_v); end
    peek(5'd1, got);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL nop_X1: got %h want %h", got, exp_v); end
  endtask

  task automatic test_async_reset();
    clear_imem();
    imem[0] = enc_i(ADDI, 12'd5, 5'd31, 5'd1);
    do_reset();
    repeat (3) step();
    peek(5'd1, got);
    n_cmp++;
    if (got !== 64'd5) begin n_bad++; $display("FAIL async_pre_X1: got %h want 5", got); end
    #3;
    RESET = 1'b0;
    #1;
    n_cmp++;
    if (PC !== 64'd0) begin n_bad++; $display("FAIL async_pc: got %h want 0", PC); end
    peek(5'd1, got);
    n_cmp++;
    if (got !== 64'd0) begin n_bad++; $display("FAIL async_X1: got %h want 0", got); end
    @(negedge CLOCK);
    RESET = 1'b1;
    step();
    n_cmp++;
    if (PC !== 64'd4) begin n_bad++; $display("FAIL restart_pc: got %h want 4", PC); end
    peek(5'd1, got);
    n_cmp++;
    if (got !== 64'd5) begin n_bad++; $display("FAIL restart_X1: got %h want 5", got); end
  endtask

  initial begin
    clear_imem();
    test_reset();
    test_arith();
    test_memory();
    test_branch();
    test_xzr_nop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
